// File: rtl/prco_writeback_if.sv
// ---------------------------------------------------------------------------
// prco_writeback_if
// Producer and register-set bundle for the PRCO writeback stage.
//   ALU producer : i_alu_valid, i_alu_sel, i_alu_dat  -> q_alu_stalled
//   LSU producer : i_lsu_valid, i_lsu_sel, i_lsu_dat  -> q_lsu_stalled
//   Write port   : q_we, q_seld, q_datd (registered, towards the register set)
// master : the surrounding core (drives producers, observes stalls/writes)
// slave  : the writeback stage itself
// ---------------------------------------------------------------------------
interface prco_writeback_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic              i_alu_valid;
  logic [SEL_W-1:0]  i_alu_sel;
  logic [DATA_W-1:0] i_alu_dat;
  logic              q_alu_stalled;

  logic              i_lsu_valid;
  logic [SEL_W-1:0]  i_lsu_sel;
  logic [DATA_W-1:0] i_lsu_dat;
  logic              q_lsu_stalled;

  logic              q_we;
  logic [SEL_W-1:0]  q_seld;
  logic [DATA_W-1:0] q_datd;

  modport master (
    output i_alu_valid, i_alu_sel, i_alu_dat,
    output i_lsu_valid, i_lsu_sel, i_lsu_dat,
    input  q_alu_stalled, q_lsu_stalled,
    input  q_we, q_seld, q_datd
  );

  modport slave (
    input  i_alu_valid, i_alu_sel, i_alu_dat,
    input  i_lsu_valid, i_lsu_sel, i_lsu_dat,
    output q_alu_stalled, q_lsu_stalled,
    output q_we, q_seld, q_datd
  );
endinterface

// File: rtl/prco_writeback.sv
// ---------------------------------------------------------------------------
// prco_writeback
// Writeback stage of the PRCO core. Arbitrates between LSU and ALU results,
// buffers ALU results in a small FIFO, issues at most one register write per
// cycle and tracks pending destinations in an 8-bit busy scoreboard.
//
// Ports:
//   i_clk        core clock, all state on rising edge
//   i_reset_n    synchronous active-low reset
//   i_en         global enable; when low only q_we is forced to 0
//   wb           producer handshakes + register-set write port (slave)
//   i_rsv_we     decode reserves destination i_rsv_sel
//   q_busy       scoreboard, bit n = register n has a write pending
//   q_wr_count   committed write counter (wraps)
//   i_fwd_sel*   forwarding queries A/B
//   q_fwd_*      forwarding hit/data for queries A/B
//
// Optional feature macro: PRCO_WB_FWD_EN
//   defined   : q_fwd_* forward the registered write port combinationally
//   undefined : q_fwd_* tied to 0
// ---------------------------------------------------------------------------
module prco_writeback #(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int DATA_W         = 16,
  parameter int SEL_W          = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  prco_writeback_if.slave   wb,
  input  logic              i_rsv_we,
  input  logic [SEL_W-1:0]  i_rsv_sel,
  output logic [7:0]        q_busy,
  output logic [15:0]       q_wr_count,
  input  logic [SEL_W-1:0]  i_fwd_sela,
  input  logic [SEL_W-1:0]  i_fwd_selb,
  output logic              q_fwd_a_hit,
  output logic [DATA_W-1:0] q_fwd_a_dat,
  output logic              q_fwd_b_hit,
  output logic [DATA_W-1:0] q_fwd_b_dat
);

  localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SEL_W + DATA_W;

  // FIFO storage and pointers
  logic [ENT_W-1:0] fifo_mem [ALU_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [SEL_W-1:0] head_sel;
  logic [DATA_W-1:0] head_dat;

  // Registered write port
  logic              we_q;
  logic [SEL_W-1:0]  seld_q;
  logic [DATA_W-1:0] datd_q;

  // Commit selection
  logic              alu_acc;
  logic              commit_we;
  logic [SEL_W-1:0]  commit_sel;
  logic [DATA_W-1:0] commit_dat;
  logic              pop;
  logic              push;
  logic              bypass;

  logic [7:0]        busy_nxt;

  assign fifo_full  = (count == CNT_W'(ALU_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign {head_sel, head_dat} = fifo_mem[rd_ptr];

  // Stalls depend only on the registered count, never on a same-cycle pop,
  // so the ALU never sees a combinational path through the commit mux.
  assign wb.q_lsu_stalled = ~i_en;
  assign wb.q_alu_stalled = ~i_en | fifo_full;

  assign alu_acc = wb.i_alu_valid & ~wb.q_alu_stalled;

  // Priority: LSU, then FIFO head, then ALU bypass (only when FIFO empty so
  // ALU results never overtake older buffered ones).
  always_comb begin
    commit_we  = 1'b0;
    commit_sel = '0;
    commit_dat = '0;
    pop        = 1'b0;
    bypass     = 1'b0;
    if (i_en) begin
      if (wb.i_lsu_valid) begin
        commit_we  = 1'b1;
        commit_sel = wb.i_lsu_sel;
        commit_dat = wb.i_lsu_dat;
      end else if (!fifo_empty) begin
        commit_we  = 1'b1;
        commit_sel = head_sel;
        commit_dat = head_dat;
        pop        = 1'b1;
      end else if (alu_acc) begin
        commit_we  = 1'b1;
        commit_sel = wb.i_alu_sel;
        commit_dat = wb.i_alu_dat;
        bypass     = 1'b1;
      end
    end
  end

  assign push = alu_acc & ~bypass;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Reservation is applied after the commit clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = q_busy;
    if (commit_we) busy_nxt[commit_sel] = 1'b0;
    if (i_rsv_we)  busy_nxt[i_rsv_sel]  = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      we_q       <= 1'b0;
      seld_q     <= '0;
      datd_q     <= '0;
      q_busy     <= '0;
      q_wr_count <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (!i_en) begin
      we_q <= 1'b0;
    end else begin
      we_q   <= commit_we;
      q_busy <= busy_nxt;
      count  <= count_nxt;
      if (commit_we) begin
        seld_q     <= commit_sel;
        datd_q     <= commit_dat;
        q_wr_count <= q_wr_count + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; an empty FIFO is defined by count alone.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && push) fifo_mem[wr_ptr] <= {wb.i_alu_sel, wb.i_alu_dat};
  end

  assign wb.q_we   = we_q;
  assign wb.q_seld = seld_q;
  assign wb.q_datd = datd_q;

`ifdef PRCO_WB_FWD_EN
  // Covers the cycle between q_we and the register set holding the value.
  assign q_fwd_a_hit = we_q && (seld_q == i_fwd_sela);
  assign q_fwd_b_hit = we_q && (seld_q == i_fwd_selb);
  assign q_fwd_a_dat = q_fwd_a_hit ? datd_q : '0;
  assign q_fwd_b_dat = q_fwd_b_hit ? datd_q : '0;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{i_fwd_sela, i_fwd_selb};
  assign q_fwd_a_hit = 1'b0;
  assign q_fwd_b_hit = 1'b0;
  assign q_fwd_a_dat = '0;
  assign q_fwd_b_dat = '0;
`endif

endmodule

// File: tb/tb_prco_writeback.sv
module tb_prco_writeback;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] dat;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rsv_we;
  logic [2:0]  rsv_sel;
  logic [2:0]  fsa;
  logic [2:0]  fsb;
  logic [7:0]  busy;
  logic [15:0] wr_count;
  logic        fa_hit;
  logic [15:0] fa_dat;
  logic        fb_hit;
  logic [15:0] fb_dat;

  prco_writeback_if #(.DATA_W(16), .SEL_W(3)) wb_if ();

  prco_writeback #(.ALU_FIFO_DEPTH(DEPTH), .DATA_W(16), .SEL_W(3)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_en        (en),
    .wb          (wb_if),
    .i_rsv_we    (rsv_we),
    .i_rsv_sel   (rsv_sel),
    .q_busy      (busy),
    .q_wr_count  (wr_count),
    .i_fwd_sela  (fsa),
    .i_fwd_selb  (fsb),
    .q_fwd_a_hit (fa_hit),
    .q_fwd_a_dat (fa_dat),
    .q_fwd_b_hit (fb_hit),
    .q_fwd_b_dat (fb_dat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered ALU results plus write-port state
  ent_t        mq[$];
  logic        m_we;
  logic [2:0]  m_sel;
  logic [15:0] m_dat;
  logic [7:0]  m_busy;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic av, input logic [2:0] as, input logic [15:0] ad,
                      input logic lv, input logic [2:0] ls, input logic [15:0] ld,
                      input logic rw, input logic [2:0] rs,
                      input logic [2:0] a, input logic [2:0] b);
    logic        c_we;
    ent_t        c;
    logic        acc;
    @(negedge clk);
    rst_n = r; en = e;
    wb_if.i_alu_valid = av; wb_if.i_alu_sel = as; wb_if.i_alu_dat = ad;
    wb_if.i_lsu_valid = lv; wb_if.i_lsu_sel = ls; wb_if.i_lsu_dat = ld;
    rsv_we = rw; rsv_sel = rs; fsa = a; fsb = b;
    #1;
    check("alu_stalled", wb_if.q_alu_stalled, (!e || mq.size() == DEPTH));
    check("lsu_stalled", wb_if.q_lsu_stalled, !e);
`ifdef PRCO_WB_FWD_EN
    check("fwd_a", {fa_hit, fa_dat}, (m_we && m_sel == a) ? {1'b1, m_dat} : 17'h0);
    check("fwd_b", {fb_hit, fb_dat}, (m_we && m_sel == b) ? {1'b1, m_dat} : 17'h0);
`else
    check("fwd_off", {fa_hit, fa_dat, fb_hit, fb_dat}, 34'h0);
`endif
    @(posedge clk);
    if (!r) begin
      mq.delete(); m_we = 0; m_sel = 0; m_dat = 0; m_busy = 0; m_cnt = 0;
    end else if (!e) begin
      m_we = 0;
    end else begin
      acc  = av && (mq.size() < DEPTH);
      c_we = 1'b1;
      if (lv) begin
        c = '{sel: ls, dat: ld};
        if (acc) mq.push_back('{sel: as, dat: ad});
      end else if (mq.size() > 0) begin
        c = mq.pop_front();
        if (acc) mq.push_back('{sel: as, dat: ad});
      end else if (acc) begin
        c = '{sel: as, dat: ad};
      end else begin
        c_we = 1'b0;
        c = '0;
      end
      m_we = c_we;
      if (c_we) begin
        m_sel = c.sel; m_dat = c.dat; m_cnt = m_cnt + 16'd1;
        m_busy[c.sel] = 1'b0;
      end
      if (rw) m_busy[rs] = 1'b1;
    end
    #1;
    check("we", wb_if.q_we, m_we);
    check("seld", wb_if.q_seld, m_sel);
    check("datd", wb_if.q_datd, m_dat);
    check("busy", busy, m_busy);
    check("wr_count", wr_count, m_cnt);
  endtask

  initial begin
    rst_n = 0; en = 1; rsv_we = 0; rsv_sel = 0; fsa = 0; fsb = 0;
    wb_if.i_alu_valid = 1; wb_if.i_alu_sel = 0; wb_if.i_alu_dat = 0;
    wb_if.i_lsu_valid = 0; wb_if.i_lsu_sel = 0; wb_if.i_lsu_dat = 0;
    @(posedge clk);
    mq.delete(); m_we = 0; m_sel = 0; m_dat = 0; m_busy = 0; m_cnt = 0;

    // Reset held for a second cycle with ALU valid
    step(0, 1, 1, 3'd2, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
    check("rst_we", wb_if.q_we, 1'b0);
    check("rst_busy", busy, 8'h00);
    check("rst_wr_count", wr_count, 16'h0);
    wb_if.i_alu_valid = 0; rst_n = 1; #1;
    check("rst_alu_stalled", wb_if.q_alu_stalled, 1'b0);

    // ALU bypass
    step(1, 1, 1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("byp_seld", wb_if.q_seld, 3'd3);
    check("byp_datd", wb_if.q_datd, 16'h1234);
    check("byp_count", wr_count, 16'd1);

    // LSU priority with ALU buffering
    step(1, 1, 1, 3'd2, 16'h0001, 1, 3'd1, 16'hAAAA, 0, 0, 0, 0);
    step(1, 1, 1, 3'd2, 16'h0002, 1, 3'd1, 16'hAAAB, 0, 0, 0, 0);
    check("prio_full_stall", wb_if.q_alu_stalled, 1'b1);
    step(1, 1, 1, 3'd2, 16'h0003, 1, 3'd1, 16'hAAAC, 0, 0, 0, 0);
    check("prio_lsu_last", wb_if.q_datd, 16'hAAAC);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("order_first", wb_if.q_datd, 16'h0001);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("order_second", wb_if.q_datd, 16'h0002);

    // Scoreboard
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0);
    check("sb_set", busy, 8'h20);
    step(1, 1, 1, 3'd5, 16'h0055, 0, 0, 0, 0, 0, 0, 0);
    check("sb_clear", busy, 8'h00);
    step(1, 1, 1, 3'd5, 16'h0056, 0, 0, 0, 1, 3'd5, 0, 0);
    check("sb_set_wins", busy[5], 1'b1);

    // Enable dropped with one buffered entry
    step(1, 1, 1, 3'd6, 16'h0666, 1, 3'd7, 16'h0777, 0, 0, 0, 0);
    step(1, 0, 1, 3'd2, 16'h0999, 1, 3'd1, 16'h0888, 1, 3'd0, 0, 0);
    check("den_we", wb_if.q_we, 1'b0);
    check("den_alu_stall", wb_if.q_alu_stalled, 1'b1);
    check("den_lsu_stall", wb_if.q_lsu_stalled, 1'b1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reen_datd", wb_if.q_datd, 16'h0666);
    check("reen_seld", wb_if.q_seld, 3'd6);

    // Forwarding
    step(1, 1, 1, 3'd4, 16'hBEEF, 0, 0, 0, 0, 0, 3'd4, 3'd6);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 1) == 1), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0), 3'($urandom),
           3'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prco_writeback.md
Name: prco_writeback

Overview:
- Writeback stage of the PRCO core. It is the writer that drives the register set's write port (i_we/i_seld/i_datd).
- Accepts results from two producers, the ALU and the load/store unit (LSU). Arbitrates between them, buffers ALU results in a small FIFO, and issues at most one register write per cycle.
- Keeps an 8-bit busy scoreboard so decode can detect read-after-write hazards on pending destinations.

Parameters:
- ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of 2, ≥2).
- DATA_W, 16, register data width.
- SEL_W, 3, register select width (8 registers).

Ports:
- i_clk  in  1  core clock, all state on rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_en  in  1  global enable. When 0, no state changes except forced q_we<=0.
- i_alu_valid  in  1  ALU result offered.
- i_alu_sel  in  SEL_W  ALU destination register.
- i_alu_dat  in  DATA_W  ALU result.
- q_alu_stalled  out  1  ALU result not accepted this cycle.
- i_lsu_valid  in  1  load result offered.
- i_lsu_sel  in  SEL_W  load destination register.
- i_lsu_dat  in  DATA_W  load data.
- q_lsu_stalled  out  1  load result not accepted this cycle.
- i_rsv_we  in  1  decode reserves a destination register.
- i_rsv_sel  in  SEL_W  register being reserved.
- q_busy  out  8  scoreboard, bit n = register n has a write pending.
- q_we  out  1  register-set write enable (registered).
- q_seld  out  SEL_W  register-set write select (registered).
- q_datd  out  DATA_W  register-set write data (registered).
- q_wr_count  out  16  committed write counter.
- i_fwd_sela  in  SEL_W  forwarding query A.
- i_fwd_selb  in  SEL_W  forwarding query B.
- q_fwd_a_hit  out  1  forwarding hit on query A.
- q_fwd_a_dat  out  DATA_W  forwarding data for query A.
- q_fwd_b_hit  out  1  forwarding hit on query B.
- q_fwd_b_dat  out  DATA_W  forwarding data for query B.

Behaviour:
- Reset (i_reset_n=0 at the clock edge) clears, taking priority over all else:
  - q_we, q_seld, q_datd, q_busy, q_wr_count all set to 0.
  - FIFO emptied (count=0, rd/wr pointers=0).
- Reset mid-operation: buffered and in-flight results are discarded, with no write issued for them.
- Handshakes:
  - Transfer occurs when valid && !stalled.
  - q_lsu_stalled = !i_en. The LSU has absolute priority and is never back-pressured while enabled.
  - q_alu_stalled = !i_en || (count==ALU_FIFO_DEPTH). This is combinational from registered count only, with no dependence on same-cycle pop.
- Commit selection per enabled cycle, in priority order:
  1. i_lsu_valid: write LSU result.
  2. FIFO not empty: pop head and write it.
  3. i_alu_valid and FIFO empty: bypass, write the ALU result directly.
  4. Otherwise q_we<=0.
- Commit registering: the selected result is registered into q_we=1/q_seld/q_datd. Latency is 1 cycle from accept to q_we for both the LSU and the ALU bypass.
- ALU push: an accepted ALU result is pushed into the FIFO unless it was used by bypass.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo ALU_FIFO_DEPTH.
- Ordering: ALU results commit in acceptance order. LSU and ALU results to the same register commit in commit-slot order (LSU first if simultaneous).
- q_wr_count increments by 1 on each cycle a write is registered. It wraps 0xFFFF→0x0000.
- i_en=0:
  - q_we<=0.
  - FIFO, count, q_busy, q_wr_count, q_seld, q_datd hold.
  - Both stalled outputs are 1.
- Scoreboard:
  - A bit is set at the edge where i_rsv_we=1 for i_rsv_sel.
  - A bit is cleared at the edge where a commit to that register is registered (q_we goes/stays 1 with that q_seld).
  - Set and clear on the same register in the same cycle: set wins.
  - Reserving an already-busy register: stays 1. There is a single outstanding write per register, and decode must stall on a busy bit.
  - i_rsv_we is ignored when i_en=0.
- The register set samples q_we/q_seld/q_datd on the following edge. Its read data reflects the write one cycle after that.

Optional Feature:
Macro PRCO_WB_FWD_EN.
- Defined: forwarding outputs are combinational.
  - q_fwd_a_hit = q_we && (q_seld==i_fwd_sela), with q_fwd_a_dat = q_datd on hit, else 0.
  - B is identical using i_fwd_selb.
  - Closes the one-cycle gap before the register set holds the new value.
- Undefined: the ports still exist and q_fwd_* are tied to 0.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with i_alu_valid=1 → q_we=0, q_busy=0x00, q_wr_count=0, q_alu_stalled=0 after release.
- ALU bypass: ALU sel=3 dat=0x1234 at cycle N, FIFO empty → q_we=1, q_seld=3, q_datd=0x1234 at N+1; q_wr_count=1.
- Priority and buffering:
  - LSU and ALU both valid for 3 cycles (LSU sel=1 dat=0xAAAA…, ALU sel=2 dat=0x0001,0x0002): 2 ALU results buffered, q_alu_stalled=1 on the 3rd cycle.
  - After LSU drops, writes 0x0001 then 0x0002 in order.
- Scoreboard: reserve r5 at N → q_busy=0x20 at N+1. ALU write r5 commits → bit clears. Simultaneous reserve r5 and commit r5 → q_busy[5] stays 1.
- i_en=0 mid-stream with FIFO count=1 → q_we=0, both stalled=1, count held. Re-enable → buffered entry written next cycle.
- PRCO_WB_FWD_EN: q_we=1, q_seld=4, q_datd=0xBEEF, i_fwd_sela=4, i_fwd_selb=6 → a_hit=1/0xBEEF, b_hit=0/0x0000. Without the macro, all q_fwd_* are 0.
